// File: rtl/cache_controller.sv
// Sequencing FSM for a 4-way set-associative cache datapath: accepts one CPU word
// access at a time, runs dirty write-back and line allocation, counts hits/misses/write-backs.
module cache_controller #(
    parameter int ADDR_WIDTH   = 32,
    parameter int WORD_SIZE    = 32,
    parameter int BLOCK_SIZE   = 128,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2,
    parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // CPU side
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_req_type,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [WORD_SIZE-1:0]    cpu_wdata,
    output logic                    cpu_resp_valid,
    output logic [WORD_SIZE-1:0]    cpu_rdata,
    // cache datapath side
    output logic [TAG_WIDTH-1:0]    cache_tag,
    output logic [INDEX_WIDTH-1:0]  cache_index,
    output logic [OFFSET_WIDTH-1:0] cache_offset,
    output logic                    cache_req_type,
    output logic [WORD_SIZE-1:0]    cache_wdata,
    output logic                    read_en_cache,
    output logic                    write_en_cache,
    output logic                    read_en_mem,
    output logic                    write_en_mem,
    input  logic                    cache_hit,
    input  logic [WORD_SIZE-1:0]    cache_rdata,
    input  logic                    victim_dirty,
    input  logic [TAG_WIDTH-1:0]    victim_tag,
    input  logic [BLOCK_SIZE-1:0]   dirty_block,
    // main-memory side
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [BLOCK_SIZE-1:0]   mem_wdata,
    input  logic                    mem_ack,
    // performance counters and FSM observation
    output logic [CNT_WIDTH-1:0]    hit_count,
    output logic [CNT_WIDTH-1:0]    miss_count,
    output logic [CNT_WIDTH-1:0]    wb_count,
    output logic [2:0]              dbg_state
);

    // Handshakes: a CPU request transfers on a rising edge with cpu_req_valid && cpu_req_ready;
    // mem_rd_req/mem_wr_req stay high until the edge that samples the one-cycle mem_ack.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COMPARE  = 3'd1,
        WB_CAPT  = 3'd2,
        WB_LATCH = 3'd3,
        WB_WAIT  = 3'd4,
        FILL_REQ = 3'd5,
        RESP     = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    CNT_MAX  = '1;
    localparam logic [OFFSET_WIDTH-1:0] OFF_ZERO = '0;

    state_t                  state, state_nx;
    logic [TAG_WIDTH-1:0]    lat_tag;
    logic [INDEX_WIDTH-1:0]  lat_index;
    logic [OFFSET_WIDTH-1:0] lat_offset;
    logic                    lat_type;
    logic [WORD_SIZE-1:0]    lat_wdata;
    logic                    first_cmp;
    logic [CNT_WIDTH-1:0]    hit_cnt, miss_cnt, wb_cnt;

    logic accept, hit_inc, miss_inc, wb_inc, load_fill_addr, load_wb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_tag    <= '0;
            lat_index  <= '0;
            lat_offset <= '0;
            lat_type   <= 1'b0;
            lat_wdata  <= '0;
            first_cmp  <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            wb_cnt     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_tag    <= cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                lat_index  <= cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
                lat_offset <= cpu_addr[OFFSET_WIDTH-1:0];
                lat_type   <= cpu_req_type;
                lat_wdata  <= cpu_wdata;
                first_cmp  <= 1'b1;
            end else if (state == COMPARE) begin
                first_cmp <= 1'b0;
            end
            // Counters stick at all-ones instead of wrapping.
            if (hit_inc && hit_cnt != CNT_MAX) begin
                hit_cnt <= hit_cnt + CNT_ONE;
            end
            if (miss_inc && miss_cnt != CNT_MAX) begin
                miss_cnt <= miss_cnt + CNT_ONE;
            end
            if (wb_inc && wb_cnt != CNT_MAX) begin
                wb_cnt <= wb_cnt + CNT_ONE;
            end
            // The victim tag is still presented during WB_LATCH; only its dirty bit was cleared.
            if (load_wb) begin
                mem_wdata <= dirty_block;
                mem_addr  <= {victim_tag, lat_index, OFF_ZERO};
            end else if (load_fill_addr) begin
                mem_addr  <= {lat_tag, lat_index, OFF_ZERO};
            end
        end
    end

    always_comb begin
        state_nx       = state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_rdata      = '0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        mem_rd_req     = 1'b0;
        mem_wr_req     = 1'b0;
        accept         = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        wb_inc         = 1'b0;
        load_fill_addr = 1'b0;
        load_wb        = 1'b0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    accept   = 1'b1;
                    state_nx = COMPARE;
                end
            end
            COMPARE: begin
                // Only the first lookup of a request counts; the post-fill lookup is bookkeeping.
                if (cache_hit) begin
                    hit_inc        = first_cmp;
                    read_en_cache  = ~lat_type;
                    write_en_cache = lat_type;
                    state_nx       = RESP;
                end else begin
                    miss_inc = first_cmp;
                    if (victim_dirty) begin
                        state_nx = WB_CAPT;
                    end else begin
                        load_fill_addr = 1'b1;
                        state_nx       = FILL_REQ;
                    end
                end
            end
            WB_CAPT: begin
                read_en_cache  = 1'b1;
                write_en_cache = 1'b1;
                read_en_mem    = 1'b1;
                write_en_mem   = 1'b1;
                state_nx       = WB_LATCH;
            end
            WB_LATCH: begin
                load_wb  = 1'b1;
                state_nx = WB_WAIT;
            end
            WB_WAIT: begin
                mem_wr_req = 1'b1;
                if (mem_ack) begin
                    wb_inc         = 1'b1;
                    load_fill_addr = 1'b1;
                    state_nx       = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_rd_req = 1'b1;
                if (mem_ack) begin
                    read_en_mem    = 1'b1;
                    write_en_cache = 1'b1;
                    state_nx       = COMPARE;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_rdata      = lat_type ? '0 : cache_rdata;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cache_tag      = lat_tag;
    assign cache_index    = lat_index;
    assign cache_offset   = lat_offset;
    assign cache_req_type = lat_type;
    assign cache_wdata    = lat_wdata;
    assign hit_count      = hit_cnt;
    assign miss_count     = miss_cnt;
    assign wb_count       = wb_cnt;
    assign dbg_state      = state;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: behavioural 4-way PLRU cache and block memory
// around the DUT, word-level reference memory feeding an expected-read-data queue.
module tb_cache_controller;

    localparam int AW = 32, WS = 32, BS = 128, IW = 4, OW = 2, TW = 26, CW = 32;
    localparam int ACK_LAT = 2;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WB_WAIT = 3'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_type = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [WS-1:0] cpu_wdata = '0, cpu_rdata;
    logic          cpu_resp_valid;
    logic [TW-1:0] cache_tag, victim_tag;
    logic [IW-1:0] cache_index;
    logic [OW-1:0] cache_offset;
    logic          cache_req_type;
    logic [WS-1:0] cache_wdata, cache_rdata;
    logic          read_en_cache, write_en_cache, read_en_mem, write_en_mem;
    logic          cache_hit, victim_dirty;
    logic [BS-1:0] dirty_block, mem_wdata;
    logic          mem_rd_req, mem_wr_req;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] hit_count, miss_count, wb_count;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    cache_controller #(
        .ADDR_WIDTH(AW), .WORD_SIZE(WS), .BLOCK_SIZE(BS), .INDEX_WIDTH(IW),
        .OFFSET_WIDTH(OW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_type(cpu_req_type), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .cache_tag(cache_tag), .cache_index(cache_index), .cache_offset(cache_offset),
        .cache_req_type(cache_req_type), .cache_wdata(cache_wdata),
        .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
        .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag), .dirty_block(dirty_block),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
        .dbg_state(dbg_state)
    );

    // ---------------- reference data ----------------
    logic [WS-1:0] ref_mem [logic [31:0]];
    logic [BS-1:0] backing [logic [31:0]];
    logic [WS-1:0] exp_q [$];

    function automatic logic [WS-1:0] word_val(input logic [31:0] a);
        return 32'hD000_0000 | a;
    endfunction

    function automatic logic [WS-1:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : word_val(a);
    endfunction

    function automatic logic [BS-1:0] blk_read(input logic [31:0] b);
        if (backing.exists(b)) return backing[b];
        return {word_val(b + 3), word_val(b + 2), word_val(b + 1), word_val(b)};
    endfunction

    function automatic logic [1:0] plru_victim(input logic [2:0] p);
        if (!p[0]) return p[1] ? 2'd1 : 2'd0;
        return p[2] ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [2:0] plru_upd(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] r;
        r = p;
        if (!w[1]) begin
            r[0] = 1'b1;
            r[1] = (w == 2'd0);
        end else begin
            r[0] = 1'b0;
            r[2] = (w == 2'd2);
        end
        return r;
    endfunction

    // ---------------- behavioural cache datapath ----------------
    logic [3:0]    m_valid [16];
    logic [3:0]    m_dirty [16];
    logic [TW-1:0] m_tag   [16][4];
    logic [BS-1:0] m_data  [16][4];
    logic [2:0]    m_plru  [16];
    logic [WS-1:0] m_rdout = '0;
    logic [BS-1:0] m_dblk = '0;
    logic [BS-1:0] mem_block = '0;
    logic          m_hit;
    logic [1:0]    m_hway, m_vway;

    always_comb begin
        m_hit  = 1'b0;
        m_hway = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (m_valid[cache_index][w] && m_tag[cache_index][w] == cache_tag) begin
                m_hit  = 1'b1;
                m_hway = 2'(w);
            end
        end
        m_vway = plru_victim(m_plru[cache_index]);
        for (int w = 3; w >= 0; w--) begin
            if (!m_valid[cache_index][w]) m_vway = 2'(w);
        end
    end

    assign cache_hit    = m_hit;
    assign cache_rdata  = m_rdout;
    assign victim_dirty = m_valid[cache_index][m_vway] & m_dirty[cache_index][m_vway];
    assign victim_tag   = m_tag[cache_index][m_vway];
    assign dirty_block  = m_dblk;

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 16; s++) begin
                m_valid[s] <= '0;
                m_dirty[s] <= '0;
                m_plru[s]  <= '0;
            end
            m_rdout <= '0;
            m_dblk  <= '0;
        end else if (read_en_cache && write_en_cache && read_en_mem && write_en_mem) begin
            m_dblk <= m_data[cache_index][m_vway];
            m_dirty[cache_index][m_vway] <= 1'b0;
        end else if (read_en_mem && write_en_cache) begin
            m_data[cache_index][m_vway]  <= mem_block;
            m_tag[cache_index][m_vway]   <= cache_tag;
            m_valid[cache_index][m_vway] <= 1'b1;
            m_dirty[cache_index][m_vway] <= 1'b0;
            m_plru[cache_index] <= plru_upd(m_plru[cache_index], m_vway);
        end else if (write_en_cache && m_hit) begin
            m_data[cache_index][m_hway][32*int'(cache_offset) +: 32] <= cache_wdata;
            m_dirty[cache_index][m_hway] <= 1'b1;
            m_plru[cache_index] <= plru_upd(m_plru[cache_index], m_hway);
        end else if (read_en_cache && m_hit) begin
            m_rdout <= m_data[cache_index][m_hway][32*int'(cache_offset) +: 32];
            m_plru[cache_index] <= plru_upd(m_plru[cache_index], m_hway);
        end
    end

    // ---------------- block memory responder and event monitor ----------------
    int            wait_cnt = 0, rd_seen = 0, wr_seen = 0, resp_seen = 0, capt_seen = 0;
    logic [AW-1:0] last_rd_addr = '0, last_wb_addr = '0;
    logic [BS-1:0] last_wb_data = '0;

    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if ((mem_rd_req || mem_wr_req) && !rst) begin
            if (wait_cnt == ACK_LAT) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_wr_req) begin
                    wr_seen++;
                    last_wb_addr = mem_addr;
                    last_wb_data = mem_wdata;
                    backing[mem_addr] = mem_wdata;
                end else begin
                    rd_seen++;
                    last_rd_addr = mem_addr;
                    mem_block = blk_read(mem_addr);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (cpu_resp_valid) resp_seen++;
        if (read_en_cache && write_en_cache && read_en_mem && write_en_mem) capt_seen++;
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns with the response cycle sampled.
    task automatic do_req(input string tag, input logic typ, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
        logic [WS-1:0] exp_v;
        int n;
        exp_v = typ ? 32'h0 : ref_read(addr);
        if (typ) ref_mem[addr] = wd;
        exp_q.push_back(exp_v);
        cpu_req_type  = typ;
        cpu_addr      = addr;
        cpu_wdata     = wd;
        cpu_req_valid = 1'b1;
        n = 0;
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (cpu_resp_valid) break;
        end
        check({tag, "_resp_valid"}, BS'(cpu_resp_valid), BS'(1'b1));
        check({tag, "_rdata"}, BS'(cpu_rdata), BS'(exp_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, w0, n;
        logic typ;
        logic [31:0] a, wd;

        repeat (3) @(negedge clk);
        check("rst_ready", BS'(cpu_req_ready), BS'(1'b1));
        check("rst_counters", BS'({hit_count, miss_count, wb_count}), '0);
        check("rst_mem_req", BS'({mem_rd_req, mem_wr_req, cpu_resp_valid}), '0);
        check("rst_enables", BS'({read_en_cache, write_en_cache, read_en_mem, write_en_mem}), '0);
        check("rst_mem_addr", BS'(mem_addr), '0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss, then repeat hit.
        do_req("rd105_miss", 1'b0, 32'h105, 32'h0, lat);
        check("miss_count_1", BS'(miss_count), BS'(1));
        check("hit_count_0", BS'(hit_count), BS'(0));
        check("fill_addr_104", BS'(last_rd_addr), BS'(32'h104));
        check("rd_seen_1", BS'(rd_seen), BS'(1));
        do_req("rd105_hit", 1'b0, 32'h105, 32'h0, lat);
        check("hit_latency", BS'(lat), BS'(2));
        check("hit_count_1", BS'(hit_count), BS'(1));
        check("no_new_fill", BS'(rd_seen), BS'(1));

        // Write hit makes the line dirty.
        do_req("wr106_hit", 1'b1, 32'h106, 32'hDEAD_BEEF, lat);
        do_req("rd106_hit", 1'b0, 32'h106, 32'h0, lat);
        check("hit_count_3", BS'(hit_count), BS'(3));
        check("line_dirty", BS'(m_dirty[1][0]), BS'(1'b1));

        // Fill set 1; PLRU then picks the dirty way 0 for 0x204.
        do_req("rd144", 1'b0, 32'h144, 32'h0, lat);
        do_req("rd184", 1'b0, 32'h184, 32'h0, lat);
        do_req("rd1c4", 1'b0, 32'h1C4, 32'h0, lat);
        check("no_wb_yet", BS'(capt_seen), BS'(0));
        do_req("rd204_wb", 1'b0, 32'h204, 32'h0, lat);
        check("wb_seen", BS'(wr_seen), BS'(1));
        check("wb_addr", BS'(last_wb_addr), BS'(32'h104));
        check("wb_data", last_wb_data, {32'hD000_0107, 32'hDEAD_BEEF, 32'hD000_0105, 32'hD000_0104});
        check("wb_count_1", BS'(wb_count), BS'(1));
        check("capt_cycles", BS'(capt_seen), BS'(1));
        check("miss_count_5", BS'(miss_count), BS'(5));
        do_req("rd106_refetch", 1'b0, 32'h106, 32'h0, lat);
        check("wb_count_still_1", BS'(wb_count), BS'(1));
        check("miss_count_6", BS'(miss_count), BS'(6));

        // Dirty 0x204 and steer PLRU back to it, then abort the write-back with rst.
        do_req("wr204", 1'b1, 32'h204, $urandom, lat);
        do_req("rd1c4_hit", 1'b0, 32'h1C4, 32'h0, lat);
        do_req("rd144_hit", 1'b0, 32'h144, 32'h0, lat);
        do_req("rd104_hit", 1'b0, 32'h104, 32'h0, lat);
        check("hit_count_7", BS'(hit_count), BS'(7));
        cpu_req_type  = 1'b0;
        cpu_addr      = 32'h244;
        cpu_req_valid = 1'b1;
        n = 0;
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        n = 0;
        while (dbg_state != ST_WB_WAIT && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_wb_wait", BS'(dbg_state), BS'(ST_WB_WAIT));
        r0 = resp_seen;
        w0 = wr_seen;
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", BS'(dbg_state), BS'(ST_IDLE));
        check("abort_mem_req", BS'({mem_rd_req, mem_wr_req, cpu_resp_valid}), '0);
        check("abort_mem_addr", BS'(mem_addr), '0);
        check("abort_mem_wdata", mem_wdata, '0);
        check("abort_counters", BS'({hit_count, miss_count, wb_count}), '0);
        check("abort_latches", BS'({cache_tag, cache_index, cache_offset}), '0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_resp", BS'(resp_seen), BS'(r0));
        check("abort_no_wb", BS'(wr_seen), BS'(w0));

        // Random reads/writes in set 3 with evictions.
        for (int i = 0; i < 8; i++) begin
            typ = 1'($urandom_range(0, 1));
            a   = (32'($urandom_range(0, 7)) << 6) | 32'h0C | 32'($urandom_range(0, 3));
            wd  = $urandom;
            do_req("rand_set3", typ, a, wd, lat);
        end

        // Counter saturation.
        force dut.miss_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.miss_cnt;
        @(negedge clk);
        check("miss_preload", BS'(miss_count), BS'(32'hFFFF_FFFE));
        do_req("rd300_miss", 1'b0, 32'h300, 32'h0, lat);
        check("miss_sat_1", BS'(miss_count), BS'(32'hFFFF_FFFF));
        do_req("rd400_miss", 1'b0, 32'h400, 32'h0, lat);
        check("miss_sat_2", BS'(miss_count), BS'(32'hFFFF_FFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
